// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: state encodings, data width, odd parity helper
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5,
        S_BREAK   = 3'd6
    } uart_state_t;

    // Parity bit that makes the total count of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_parity.sv
// rtl/uart_rx_parity.sv - odd-parity UART receiver: byte recovery with parity and stop-bit checks
module uart_rx_parity
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Rx_Idle
);

    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic                 rx_s;
    uart_state_t          state, state_n;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_bit, par_bit_n;
    logic [DATA_BITS-1:0] rx_byte_n;
    logic                 rx_dv_n, parity_err_n, frame_err_n;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .d       (i_Rx_Serial),
        .q       (rx_s)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state        <= S_IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            par_bit      <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Rx_Idle    <= 1'b1;
        end else begin
            state        <= state_n;
            clk_cnt      <= clk_cnt_n;
            bit_idx      <= bit_idx_n;
            shift        <= shift_n;
            par_bit      <= par_bit_n;
            o_Rx_DV      <= rx_dv_n;
            o_Rx_Byte    <= rx_byte_n;
            o_Parity_Err <= parity_err_n;
            o_Frame_Err  <= frame_err_n;
            o_Rx_Idle    <= (state_n == S_IDLE);
        end
    end

    always_comb begin
        state_n      = state;
        clk_cnt_n    = clk_cnt;
        bit_idx_n    = bit_idx;
        shift_n      = shift;
        par_bit_n    = par_bit;
        rx_byte_n    = o_Rx_Byte;
        parity_err_n = o_Parity_Err;
        frame_err_n  = o_Frame_Err;
        rx_dv_n      = 1'b0;

        case (state)
            S_IDLE: begin
                clk_cnt_n = '0;
                bit_idx_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end

            // A start bit that is no longer low at its midpoint was a glitch.
            S_START: begin
                if (clk_cnt == HALF) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (clk_cnt == LAST) begin
                    clk_cnt_n        = '0;
                    shift_n[bit_idx] = rx_s;
                    bit_idx_n        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = S_PARITY;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end

            S_PARITY: begin
                if (clk_cnt == LAST) begin
                    clk_cnt_n = '0;
                    par_bit_n = rx_s;
                    state_n   = S_STOP;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end

            // Every completed frame is delivered; a low stop bit means a break may follow.
            S_STOP: begin
                if (clk_cnt == LAST) begin
                    clk_cnt_n    = '0;
                    rx_byte_n    = shift;
                    parity_err_n = (par_bit != odd_parity(shift));
                    frame_err_n  = ~rx_s;
                    rx_dv_n      = 1'b1;
                    state_n      = rx_s ? S_CLEANUP : S_BREAK;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end

            S_CLEANUP: begin
                state_n = S_IDLE;
            end

            S_BREAK: begin
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
